// File: rtl/reg_file_sb.sv
// reg_file_sb: registered-read register file with busy scoreboard and sticky WAW flag; define REG_FILE_SB_BYPASS_EN for same-cycle write-to-read forwarding
module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int SP_IDX = 14,
  parameter logic [31:0] SP_INIT = 32'h1000,
  parameter bit R0_ZERO = 1'b0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              IsWb,
  input  logic [ADDR_W-1:0] a3,
  input  logic [DATA_W-1:0] d3,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  output logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] d2,
  output logic              busy1,
  output logic              busy2,
  input  logic              IsRsv,
  input  logic [ADDR_W-1:0] a_rsv,
  output logic              rsv_err
);
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] SP_RST = DATA_W'(SP_INIT);
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [DATA_W-1:0] d1_q, d1_d, d2_q, d2_d;
  logic busy1_q, busy1_d, busy2_q, busy2_d, rsv_err_q, rsv_err_d;
  logic wr_ok, rsv_ok;
  assign wr_ok = IsWb && !(R0_ZERO && a3 == '0);
  assign rsv_ok = IsRsv && !(R0_ZERO && a_rsv == '0);
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) regs_d[a3] = d3;
    if (IsWb) busy_d[a3] = 1'b0;
    if (rsv_ok) busy_d[a_rsv] = 1'b1;
    rsv_err_d = rsv_err_q | (IsRsv & busy_q[a_rsv] & ~(IsWb & (a3 == a_rsv)));
`ifdef REG_FILE_SB_BYPASS_EN
    d1_d = (wr_ok && a3 == a1) ? d3 : regs_q[a1];
    d2_d = (wr_ok && a3 == a2) ? d3 : regs_q[a2];
    busy1_d = (wr_ok && a3 == a1) ? (rsv_ok && a_rsv == a1) : busy_q[a1];
    busy2_d = (wr_ok && a3 == a2) ? (rsv_ok && a_rsv == a2) : busy_q[a2];
`else
    d1_d = regs_q[a1];
    d2_d = regs_q[a2];
    busy1_d = busy_q[a1];
    busy2_d = busy_q[a2];
`endif
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= (i == SP_IDX) ? SP_RST : '0;
      busy_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
      busy1_q <= 1'b0;
      busy2_q <= 1'b0;
      rsv_err_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
      busy1_q <= busy1_d;
      busy2_q <= busy2_d;
      rsv_err_q <= rsv_err_d;
    end
  end
  assign d1 = d1_q;
  assign d2 = d2_q;
  assign busy1 = busy1_q;
  assign busy2 = busy2_q;
  assign rsv_err = rsv_err_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed self-checking bench for reg_file_sb (default and R0_ZERO instances)
module tb_reg_file_sb;
`ifdef REG_FILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic Clk = 1'b0;
  logic Reset, IsWb, IsRsv;
  logic [3:0] a3, a1, a2, a_rsv;
  logic [31:0] d3;
  logic [31:0] d1, d2, zd1, zd2;
  logic busy1, busy2, rsv_err, zbusy1, zbusy2, zrsv_err;
  int checks = 0;
  int errors = 0;
  always #5 Clk = ~Clk;
  reg_file_sb dut (
    .Clk(Clk), .Reset(Reset), .IsWb(IsWb), .a3(a3), .d3(d3), .a1(a1), .a2(a2),
    .d1(d1), .d2(d2), .busy1(busy1), .busy2(busy2), .IsRsv(IsRsv), .a_rsv(a_rsv), .rsv_err(rsv_err)
  );
  reg_file_sb #(.R0_ZERO(1'b1)) dut_z (
    .Clk(Clk), .Reset(Reset), .IsWb(IsWb), .a3(a3), .d3(d3), .a1(a1), .a2(a2),
    .d1(zd1), .d2(zd2), .busy1(zbusy1), .busy2(zbusy2), .IsRsv(IsRsv), .a_rsv(a_rsv), .rsv_err(zrsv_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge Clk);
    #1;
  endtask
  task automatic idle;
    IsWb = 1'b0;
    IsRsv = 1'b0;
  endtask
  initial begin
    Reset = 1'b1; IsWb = 1'b0; IsRsv = 1'b0;
    a1 = '0; a2 = '0; a3 = '0; a_rsv = '0; d3 = '0;
    step();
    Reset = 1'b0; a1 = 4'd14; a2 = 4'd3;
    step();
    chk("rst_sp", d1, 32'h1000);
    chk("rst_d2", d2, 32'h0);
    chk("rst_busy1", {31'b0, busy1}, 32'h0);
    chk("rst_busy2", {31'b0, busy2}, 32'h0);
    chk("rst_err", {31'b0, rsv_err}, 32'h0);
    chk("z_rst_sp", zd1, 32'h1000);
    IsWb = 1'b1; a3 = 4'd5; d3 = 32'hDEADBEEF; a1 = 4'd5;
    step();
    chk("wb_same_cycle", d1, BYP ? 32'hDEADBEEF : 32'h0);
    idle();
    step();
    chk("wb_next_cycle", d1, 32'hDEADBEEF);
    IsRsv = 1'b1; a_rsv = 4'd7; a1 = 4'd7;
    step();
    chk("rsv7_pre", {31'b0, busy1}, 32'h0);
    idle();
    step();
    chk("rsv7_busy", {31'b0, busy1}, 32'h1);
    IsWb = 1'b1; a3 = 4'd7; d3 = 32'd9;
    step();
    chk("wb7_same_busy", {31'b0, busy1}, BYP ? 32'h0 : 32'h1);
    chk("wb7_same_d", d1, BYP ? 32'd9 : 32'd0);
    idle();
    step();
    chk("wb7_busy", {31'b0, busy1}, 32'h0);
    chk("wb7_d", d1, 32'd9);
    chk("wb7_err", {31'b0, rsv_err}, 32'h0);
    IsRsv = 1'b1; a_rsv = 4'd6;
    step();
    IsWb = 1'b1; a3 = 4'd6; d3 = 32'd66;
    step();
    idle(); a1 = 4'd6;
    step();
    chk("rsvwb6_busy", {31'b0, busy1}, 32'h1);
    chk("rsvwb6_d", d1, 32'd66);
    chk("rsvwb6_err", {31'b0, rsv_err}, 32'h0);
    IsWb = 1'b1; a3 = 4'd6;
    step();
    idle(); IsRsv = 1'b1; a_rsv = 4'd0; a1 = 4'd0;
    step();
    idle();
    step();
    chk("r0_rsv_busy_def", {31'b0, busy1}, 32'h1);
    chk("r0_rsv_busy_z", {31'b0, zbusy1}, 32'h0);
    IsWb = 1'b1; a3 = 4'd0; d3 = 32'd5;
    step();
    idle();
    step();
    chk("r0_wr_def", d1, 32'd5);
    chk("r0_busy_def", {31'b0, busy1}, 32'h0);
    chk("r0_wr_z", zd1, 32'd0);
    chk("r0_busy_z", {31'b0, zbusy1}, 32'h0);
    chk("z_err", {31'b0, zrsv_err}, 32'h0);
    IsRsv = 1'b1; a_rsv = 4'd4;
    step();
    chk("waw_first", {31'b0, rsv_err}, 32'h0);
    step();
    chk("waw_second", {31'b0, rsv_err}, 32'h1);
    idle();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("waw_sticky", {31'b0, rsv_err}, 32'h1);
    end
    Reset = 1'b1;
    step();
    chk("waw_reset", {31'b0, rsv_err}, 32'h0);
    Reset = 1'b0; IsRsv = 1'b1; a_rsv = 4'd2; IsWb = 1'b1; a3 = 4'd3; d3 = 32'h55; a1 = 4'd3; a2 = 4'd2;
    step();
    idle(); Reset = 1'b1;
    step();
    chk("mid_rst_d1", d1, 32'h0);
    chk("mid_rst_d2", d2, 32'h0);
    Reset = 1'b0;
    step();
    chk("post_rst_reg3", d1, 32'h0);
    chk("post_rst_busy2", {31'b0, busy2}, 32'h0);
    chk("post_rst_err", {31'b0, rsv_err}, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the core's 16x32 register file.
- Data width and register count are configurable.
- Reads are registered: one-cycle latency, clean with respect to the clock edge.
- Adds a per-register busy scoreboard (reserve on issue, clear on writeback), an optional hardwired-zero register and a sticky hazard-error flag.
- Sits between decode/operand-fetch and writeback of the SimpleRisc pipeline.

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 4: address width; NUM_REGS = 2**ADDR_W.
- SP_IDX, 14: index of the stack pointer register.
- SP_INIT, 32'h1000: reset value of register SP_IDX, truncated to DATA_W.
- R0_ZERO, 0: when 1, register 0 reads as 0, ignores writes and is never busy.

Ports:
- Clk, input, 1: clock, rising edge.
- Reset, input, 1: synchronous, active-high reset.
- IsWb, input, 1: write enable for port 3.
- a3, input, ADDR_W: write address.
- d3, input, DATA_W: write data.
- a1, input, ADDR_W: read address, port 1.
- a2, input, ADDR_W: read address, port 2.
- d1, output, DATA_W: read data, port 1 (registered).
- d2, output, DATA_W: read data, port 2 (registered).
- busy1, output, 1: scoreboard bit for a1 (registered alongside d1).
- busy2, output, 1: scoreboard bit for a2 (registered alongside d2).
- IsRsv, input, 1: reserve request; marks register a_rsv busy.
- a_rsv, input, ADDR_W: register to reserve.
- rsv_err, output, 1: sticky hazard flag.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous, active-high; all state changes occur on the rising edge of Clk.
- Reset (Reset=1 at posedge):
  - Regs[SP_IDX] <= SP_INIT; all other registers <= 0.
  - All busy bits <= 0.
  - d1, d2, busy1, busy2, rsv_err <= 0.
  - Reset overrides IsWb and IsRsv in the same cycle.
  - Reset asserted mid-operation discards any pending reservations.
- Write: if IsWb=1 at posedge, Regs[a3] <= d3.
  - With R0_ZERO=1 and a3=0, the write is dropped.
  - The write is visible to a read presented in the next cycle (see Optional Feature for same-cycle reads).
- Read: at each posedge, d1 <= Regs[a1] and d2 <= Regs[a2].
  - Latency is 1 cycle; d1/d2 hold until the next posedge.
  - a1 == a2 is legal; both ports return the same value.
  - With R0_ZERO=1, address 0 returns 0.
- Scoreboard, next-state rules for busy[i]:
  - Set if IsRsv=1 and a_rsv=i.
  - Else cleared if IsWb=1 and a3=i.
  - Else held.
  - Simultaneous reserve and writeback to the same index: the reservation wins, so the bit stays/becomes 1 (a new producer has issued).
  - With R0_ZERO=1, busy[0] is constant 0 and reserving index 0 is ignored.
- busy1/busy2: registered at posedge from busy[a1]/busy[a2]. They reflect pre-update state unless BYPASS_EN (see below).
- rsv_err: set to 1 at posedge when IsRsv=1, busy[a_rsv]=1 and no same-cycle IsWb to a_rsv (a WAW reservation on an outstanding register).
  - Once set, it remains 1 until Reset.
  - The offending reservation is still applied, and the bit stays 1.
- No other state. No combinational path from any input to any output.

Optional Feature:
- Macro: REG_FILE_SB_BYPASS_EN.
- Defined:
  - Same-cycle write-to-read forwarding: if IsWb=1 and a3==a1 (not R0 under R0_ZERO), d1 <= d3. Same rule for port 2.
  - busy1 <= 0 in that case, unless IsRsv=1 and a_rsv==a1 in the same cycle, in which case busy1 <= 1.
  - Result: a read issued in the writeback cycle gets the new value one cycle later.
- Undefined:
  - Reads return the pre-write array contents and the pre-update busy bit.
  - Software/pipeline must wait one extra cycle after writeback.

Test Plan:
1. Reset for 1 cycle; then a1=14, a2=3 -> next cycle d1=32'h1000, d2=0, busy1=busy2=0, rsv_err=0.
2. IsWb=1, a3=5, d3=32'hDEADBEEF in cycle N; a1=5 in cycle N+1 -> d1=32'hDEADBEEF after posedge N+2. Same-cycle read in cycle N:
   - BYPASS_EN defined -> d1=32'hDEADBEEF.
   - BYPASS_EN undefined -> d1=old value 0.
3. IsRsv=1, a_rsv=7; next cycle a1=7 -> busy1=1. IsWb=1, a3=7, d3=9 -> afterwards busy1=0, d1=9. rsv_err stays 0.
4. IsRsv=1, a_rsv=4 twice with no writeback between -> rsv_err=1 after the second posedge; it stays 1 through 10 idle cycles and clears only on Reset.
5. Same cycle IsRsv=1, a_rsv=6 and IsWb=1, a3=6 (6 previously busy) -> busy[6]=1 and rsv_err=0. With R0_ZERO=1: IsWb to a3=0 with d3=5, then read a1=0 -> d1=0, busy1=0.
6. Reset asserted the cycle after reserving 2 and writing 32'h55 to reg 3 -> Regs[3]=0, busy[2]=0, d1=d2=0 on the following cycle.
